// File: rtl/ccff_pkg.sv
// ccff_pkg: shared FSM states and default sizes for the configuration-chain loader.
package ccff_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, PROBE, DONE} state_t;
    localparam int WORD_W_DEF    = 8;
    localparam int CHAIN_LEN_DEF = 48;
    localparam int LEN_W_DEF     = 8;
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: holds one bitstream word and hands it out MSB-first, one bit per cycle.
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clr_i,
    input  logic              act_i,
    input  logic              fin_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              shift_o,
    output logic              msb_o
);
    localparam int RW = $clog2(WORD_W + 1);
    logic [WORD_W-1:0] word_q, word_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              acc;
    // A word may land while its predecessor's last bit leaves, unless that bit ends the chain.
    always_comb begin
        shift_o = act_i && rem_q != '0;
        ready_o = act_i && (rem_q == '0 || (rem_q == RW'(1) && !fin_i));
        acc     = valid_i && ready_o;
        word_d  = acc ? data_i : shift_o ? word_q << 1 : word_q;
        rem_d   = clr_i ? '0 : acc ? RW'(WORD_W) : shift_o ? rem_q - RW'(1) : rem_q;
    end
    assign msb_o = word_q[WORD_W-1];
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            word_q <= '0;
            rem_q  <= '0;
        end else begin
            word_q <= word_d;
            rem_q  <= rem_d;
        end
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: drives the serial config chain with a bitstream, or probes its length.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              probe,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  probe_len
);
    localparam logic [LEN_W-1:0] LEN  = LEN_W'(CHAIN_LEN);
    localparam logic [LEN_W-1:0] LAST = LEN_W'(CHAIN_LEN - 1);
    localparam logic [LEN_W-1:0] TMO  = LEN_W'(2 * CHAIN_LEN);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             head_q, head_d, en_q, en_d, err_q, err_d;
    logic             shift, msb;

    ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .prog_clk(prog_clk),
        .pReset(pReset),
        .clr_i(state_q == IDLE),
        .act_i(state_q == LOAD),
        .fin_i(cnt_q == LAST),
        .data_i(cfg_data),
        .valid_i(cfg_valid),
        .ready_o(cfg_ready),
        .shift_o(shift),
        .msb_o(msb)
    );

    // In PROBE, cnt starts at all-ones so it reads 1 once the launched 1 sits in the first flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        head_d  = head_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = probe ? FLUSH : LOAD;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            LOAD: begin
                en_d    = shift;
                head_d  = shift ? msb : head_q;
                cnt_d   = cnt_q + LEN_W'(shift);
                state_d = shift && cnt_q == LAST ? DONE : LOAD;
            end
            FLUSH: begin
                en_d   = 1'b1;
                head_d = 1'b0;
                cnt_d  = cnt_q == LAST ? '1 : cnt_q + LEN_W'(1);
                err_d  = err_q || ccff_tail;
                state_d = cnt_q == LAST ? PROBE : FLUSH;
            end
            PROBE: begin
                en_d   = 1'b1;
                head_d = cnt_q == '1;
                cnt_d  = cnt_q + LEN_W'(1);
                if (ccff_tail) begin
                    len_d   = cnt_q;
                    err_d   = cnt_q != LEN;
                    state_d = DONE;
                end else if (cnt_q == TMO) begin
                    len_d   = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            head_q  <= head_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign ccff_head     = head_q;
    assign config_enable = en_q;
    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
    assign error         = err_q;
    assign probe_len     = len_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: 48- and 44-flop loaders sharing stimulus, each driving its own chain model.
module tb_ccff_chain_loader;
    logic       prog_clk = 1'b0, pReset = 1'b1, start = 1'b0, probe = 1'b0, cfg_valid = 1'b0, clr_m = 1'b1;
    logic [7:0] cfg_data = 8'h00;
    logic       tail_a, head_a, en_a, rdy_a, busy_a, done_a, err_a;
    logic       tail_b, head_b, en_b, rdy_b, busy_b, done_b, err_b;
    logic [7:0] len_a, len_b;
    logic [47:0] ch_a = '0;
    logic [43:0] ch_b = '0;
    logic [47:0] stream = 48'hA53CFF00817E;
    logic [7:0]  words [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    int tsel = 0;
    int checks = 0, errors = 0;
    int en_a_n, en_b_n, gap_a, dones_a, dones_b, acc;
    logic rdy6;

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (clr_m) begin
            ch_a <= '0;
            ch_b <= '0;
        end else begin
            if (en_a) ch_a <= {ch_a[46:0], head_a};
            if (en_b) ch_b <= {ch_b[42:0], head_b};
        end
    end
    assign tail_a = tsel == 2 ? 1'b0 : tsel == 1 ? ch_a[46] : ch_a[47];
    assign tail_b = tsel == 2 ? 1'b0 : ch_b[43];

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(48), .LEN_W(8)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .probe(probe),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy_a), .ccff_tail(tail_a),
        .ccff_head(head_a), .config_enable(en_a), .busy(busy_a), .done(done_a),
        .error(err_a), .probe_len(len_a));

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(44), .LEN_W(8)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .probe(probe),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy_b), .ccff_tail(tail_b),
        .ccff_head(head_b), .config_enable(en_b), .busy(busy_b), .done(done_b),
        .error(err_b), .probe_len(len_b));

    task automatic run_load(input int stall_len);
        int idx = 0, st = 0, first = -1, last = -1, cyc = 0, post = 0;
        logic rdy_s = 1'b0;
        en_a_n = 0; en_b_n = 0; dones_a = 0; dones_b = 0; rdy6 = 1'b0;
        @(negedge prog_clk); start = 1'b1; probe = 1'b0;
        @(negedge prog_clk); start = 1'b0;
        while (post < 3 && cyc < 300) begin
            if (cfg_valid && rdy_s) idx++;
            if (en_a) begin
                en_a_n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            en_b_n  += int'(en_b);
            dones_a += int'(done_a);
            dones_b += int'(done_b);
            if (idx >= 6 && (rdy_a || rdy_b)) rdy6 = 1'b1;
            if (idx == 2 && rdy_a && st < stall_len) begin
                cfg_valid = 1'b0;
                st++;
            end else begin
                cfg_valid = idx < 6;
                cfg_data  = words[idx % 6];
            end
            rdy_s = rdy_a;
            if (dones_a > 0 && !busy_a && !busy_b) post++;
            cyc++;
            @(negedge prog_clk);
        end
        cfg_valid = 1'b0;
        acc = idx;
        gap_a = last - first + 1 - en_a_n;
    endtask

    task automatic run_probe(input int sel);
        int cyc = 0;
        tsel = sel; dones_a = 0; dones_b = 0;
        @(negedge prog_clk); clr_m = 1'b1;
        @(negedge prog_clk); clr_m = 1'b0; start = 1'b1; probe = 1'b1;
        @(negedge prog_clk); start = 1'b0; probe = 1'b0;
        while ((busy_a || busy_b) && cyc < 400) begin
            dones_a += int'(done_a);
            dones_b += int'(done_b);
            cyc++;
            @(negedge prog_clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge prog_clk);
        checks++; if (head_a !== 1'b0) begin errors++; $display("FAIL rst_head got %b want 0", head_a); end
        checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", en_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", rdy_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", err_a); end
        checks++; if (len_a !== 8'h00) begin errors++; $display("FAIL rst_len got %0d want 0", len_a); end
        pReset = 1'b0; clr_m = 1'b0;
    endtask

    task automatic test_load;
        logic [43:0] exp_b;
        exp_b = stream[47:4];
        run_load(0);
        checks++; if (en_a_n !== 48) begin errors++; $display("FAIL load_en got %0d want 48", en_a_n); end
        checks++; if (gap_a !== 0) begin errors++; $display("FAIL load_gap got %0d want 0", gap_a); end
        checks++; if (ch_a !== stream) begin errors++; $display("FAIL load_chain got %h want %h", ch_a, stream); end
        checks++; if (dones_a !== 1) begin errors++; $display("FAIL load_done got %0d want 1", dones_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL load_error got %b want 0", err_a); end
        checks++; if (acc !== 6) begin errors++; $display("FAIL load_words got %0d want 6", acc); end
        checks++; if (rdy6 !== 1'b0) begin errors++; $display("FAIL load_ready_after6 got %b want 0", rdy6); end
        checks++; if (en_b_n !== 44) begin errors++; $display("FAIL short_en got %0d want 44", en_b_n); end
        checks++; if (ch_b !== exp_b) begin errors++; $display("FAIL short_chain got %h want %h", ch_b, exp_b); end
        checks++; if (dones_b !== 1) begin errors++; $display("FAIL short_done got %0d want 1", dones_b); end
    endtask

    task automatic test_stall;
        run_load(3);
        checks++; if (en_a_n !== 48) begin errors++; $display("FAIL stall_en got %0d want 48", en_a_n); end
        checks++; if (gap_a !== 3) begin errors++; $display("FAIL stall_gap got %0d want 3", gap_a); end
        checks++; if (ch_a !== stream) begin errors++; $display("FAIL stall_chain got %h want %h", ch_a, stream); end
        checks++; if (dones_a !== 1) begin errors++; $display("FAIL stall_done got %0d want 1", dones_a); end
        checks++; if (en_b_n !== 44) begin errors++; $display("FAIL stall_short_en got %0d want 44", en_b_n); end
    endtask

    task automatic test_probe;
        run_probe(0);
        checks++; if (len_a !== 8'd48) begin errors++; $display("FAIL probe48_len got %0d want 48", len_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL probe48_error got %b want 0", err_a); end
        checks++; if (dones_a !== 1) begin errors++; $display("FAIL probe48_done got %0d want 1", dones_a); end
        checks++; if (len_b !== 8'd44) begin errors++; $display("FAIL probe44_len got %0d want 44", len_b); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL probe44_error got %b want 0", err_b); end
        run_probe(1);
        checks++; if (len_a !== 8'd47) begin errors++; $display("FAIL probe47_len got %0d want 47", len_a); end
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL probe47_error got %b want 1", err_a); end
        checks++; if (dones_a !== 1) begin errors++; $display("FAIL probe47_done got %0d want 1", dones_a); end
    endtask

    task automatic test_stuck;
        run_probe(2);
        checks++; if (len_a !== 8'hFF) begin errors++; $display("FAIL stuck_len got %0d want 255", len_a); end
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL stuck_error got %b want 1", err_a); end
        checks++; if (dones_a !== 1) begin errors++; $display("FAIL stuck_done got %0d want 1", dones_a); end
        checks++; if (len_b !== 8'hFF) begin errors++; $display("FAIL stuck_short_len got %0d want 255", len_b); end
        tsel = 0;
    endtask

    task automatic test_error_clear;
        run_load(0);
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL errclr_a got %b want 0", err_a); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL errclr_b got %b want 0", err_b); end
        checks++; if (len_a !== 8'hFF) begin errors++; $display("FAIL errclr_len_kept got %0d want 255", len_a); end
    endtask

    task automatic test_reset_mid_load;
        int cyc = 0, n = 0;
        @(negedge prog_clk); start = 1'b1; probe = 1'b0;
        @(negedge prog_clk); start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hA5;
        while (n < 20 && cyc < 100) begin
            @(negedge prog_clk);
            n += int'(en_a);
            cyc++;
        end
        checks++; if (n !== 20) begin errors++; $display("FAIL midrst_reach got %0d want 20", n); end
        pReset = 1'b1;
        @(negedge prog_clk);
        checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL midrst_en got %b want 0", en_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", rdy_a); end
        pReset = 1'b0; cfg_valid = 1'b0;
        run_load(0);
        checks++; if (en_a_n !== 48) begin errors++; $display("FAIL reload_en got %0d want 48", en_a_n); end
        checks++; if (ch_a !== stream) begin errors++; $display("FAIL reload_chain got %h want %h", ch_a, stream); end
        checks++; if (dones_a !== 1) begin errors++; $display("FAIL reload_done got %0d want 1", dones_a); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_stall;
        test_probe;
        test_stuck;
        test_error_clear;
        test_reset_mid_load;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
